// File: rtl/pc_link_stack.sv
// Program counter with a bounded hardware return-address stack.
// Supports byte-lane loads, signed relative branches, and call/return.
module pc_link_stack #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       BYTE_W      = 8,
  parameter int unsigned       STEP        = 2,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                               clock,
  input  logic                               n_reset,
  input  logic [ADDR_W-1:0]                  data_in,
  input  logic [ADDR_W/BYTE_W-1:0]           load_en,
  input  logic                               increase,
  input  logic                               rel_en,
  input  logic [ADDR_W-1:0]                  rel_off,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               err_clr,
  output logic [ADDR_W-1:0]                  pc_out,
  output logic [ADDR_W-1:0]                  link_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               ovf_err,
  output logic                               unf_err
);

  localparam int unsigned LANES   = ADDR_W / BYTE_W;
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
  // Storage is sized to the full depth-counter range so it can be indexed
  // directly by depth; slots at or above STACK_DEPTH are never written.
  localparam int unsigned SLOTS   = 1 << DEPTH_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  stack_q [SLOTS];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, unf_q;
  logic               ovf_set, unf_set, push;
  logic               is_full, is_empty;
  logic [ADDR_W-1:0]  top, ret_addr;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign top      = stack_q[depth_q - 1'b1];
  assign ret_addr = pc_q + ADDR_W'(STEP);

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ret) begin
      if (!is_empty) begin
        pc_d    = top;
        depth_d = depth_q - 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (call) begin
      if (!is_full) begin
        push    = 1'b1;
        pc_d    = data_in;
        depth_d = depth_q + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (|load_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (load_en[i]) pc_d[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
      end
    end else if (rel_en) begin
      pc_d = pc_q + rel_off;
    end else if (increase) begin
      pc_d = pc_q + ADDR_W'(STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      pc_q    <= RESET_PC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) stack_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      if (push) stack_q[depth_q] <= ret_addr;
      // A new error in the same cycle as err_clr keeps the flag set.
      ovf_q   <= ovf_set | (ovf_q & ~err_clr);
      unf_q   <= unf_set | (unf_q & ~err_clr);
    end
  end

  assign pc_out      = pc_q;
  assign link_out    = is_empty ? '0 : top;
  assign depth       = depth_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule
